fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- IF stage of the MIPS pipeline: owns the program counter and the IF/ID pipeline register.
- Drives a word-indexed PC to the instruction memory, which reads combinationally.
- Captures the returned instruction and PC+1 into IF/ID for the decode stage.
- Handles decode stalls, EX-stage branch redirects, and a halt when fetch runs off the end of memory.

Parameters:
- RESET_PC, 0, word index loaded into the PC on reset.
- IMEM_DEPTH, 256, number of instruction words; the last valid index is IMEM_DEPTH-1.
- PC_W, 32, width of the PC and branch target.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- stall  input  1  ID hazard stall: hold PC and IF/ID.
- branch_taken  input  1  EX redirect request.
- branch_target  input  PC_W  word index for the redirect.
- pc_out  output  PC_W  address to instruction memory (registered).
- instr_in  input  32  instruction memory data for pc_out, same cycle.
- ifid_instr  output  32  IF/ID instruction.
- ifid_pc_plus1  output  PC_W  IF/ID word index of the next sequential instruction.
- ifid_valid  output  1  IF/ID holds a real instruction (0 = bubble).
- halted  output  1  fetch is in HALT state.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - pc_out=RESET_PC; ifid_instr=0; ifid_pc_plus1=0; ifid_valid=0; halted=0; state=RUN.
  - Reset asserted mid-operation discards any in-flight fetch immediately.
- States: RUN and HALT. `halted` is 1 exactly when state=HALT.
- Latency:
  - pc_out is presented in cycle n; instr_in is sampled at the end of cycle n.
  - The instruction appears in IF/ID in cycle n+1.
  - Zero-bubble sequential throughput: one instruction per cycle.
- Priority per rising edge, in order: branch_taken, then stall, then normal advance.
- Branch (any state):
  - pc_out<=branch_target; ifid_valid<=0, squashing the wrong-path fetch; state<=RUN.
  - ifid_instr and ifid_pc_plus1 may change but are don't-care while ifid_valid=0.
  - branch_taken together with stall: branch wins and stall is ignored that cycle.
  - A branch_target >= IMEM_DEPTH puts the block in HALT on the next edge. That fetch is not captured (ifid_valid<=0).
- Stall (no branch): pc_out, ifid_instr, ifid_pc_plus1, ifid_valid, and state all hold.
- RUN, normal advance:
  - ifid_instr<=instr_in; ifid_pc_plus1<=pc_out+1; ifid_valid<=1.
  - If pc_out==IMEM_DEPTH-1: pc_out holds and state<=HALT. The last instruction is still captured.
  - Otherwise pc_out<=pc_out+1.
- HALT, no branch: pc_out holds; ifid_valid<=0 every cycle, delivering bubbles; stall has no further effect.
- Arithmetic: pc_out+1 is computed at PC_W bits. The PC never wraps, because HALT occurs first.

Optional Feature:
- Macro: FETCH_STATS_EN.
- Defined: adds two 32-bit outputs, both cleared by rst_n and saturating at 0xFFFFFFFF.
  - fetch_count increments on each edge where ifid_valid is loaded with 1.
  - bubble_count increments on each edge where ifid_valid is loaded with 0 due to a branch or HALT.
  - Neither counter changes on stall cycles.
- Undefined: the ports and logic are absent. All other behaviour is identical.

Test Plan:
- Sequential fetch: imem model holds word 0=0x01095020, word 1=0x01095022, word 2=0x21090001; release rst_n.
  - Required: pc_out=0,1,2 on successive cycles.
  - Required: IF/ID shows (0x01095020, pc+1=1, valid=1), then (0x01095022, 2, 1), then (0x21090001, 3, 1).
- Stall: assert stall for 2 cycles while pc_out=3.
  - Required: pc_out stays 3 and IF/ID is unchanged for 2 cycles.
  - Required: after release, pc_out=4 and IF/ID holds word 3.
- Branch squash: at pc_out=11 (word 11=0x12120000), pulse branch_taken with target=2 together with stall=1.
  - Required: next cycle pc_out=2 and ifid_valid=0.
  - Required: the following cycle IF/ID holds word 2 with valid=1.
- End of memory: run until pc_out=255.
  - Required: word 255 is captured with ifid_pc_plus1=256; then halted=1, pc_out stays 255, and ifid_valid=0 on every subsequent cycle.
  - Required: a branch with target=0 from HALT gives halted=0 and pc_out=0.
- Async reset: drop rst_n mid-cycle while pc_out=7.
  - Required: pc_out=0, ifid_valid=0, and halted=0 immediately, without waiting for a clock edge.
- With FETCH_STATS_EN: 10 sequential fetches, 1 branch, 3 stall cycles.
  - Required: fetch_count=10 and bubble_count=1.

Source files
------------

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - MIPS IF stage: program counter, IF/ID register, RUN/HALT control
// Define FETCH_STATS_EN to add saturating fetch_count/bubble_count outputs.
module fetch_stage #(
  parameter int RESET_PC   = 0,
  parameter int IMEM_DEPTH = 256,
  parameter int PC_W       = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] branch_target,
  output logic [PC_W-1:0] pc_out,
  input  logic [31:0]     instr_in,
  output logic [31:0]     ifid_instr,
  output logic [PC_W-1:0] ifid_pc_plus1,
  output logic            ifid_valid,
  output logic            halted
`ifdef FETCH_STATS_EN
  , output logic [31:0]   fetch_count
  , output logic [31:0]   bubble_count
`endif
);

  typedef enum logic {RUN = 1'b0, HALT = 1'b1} state_e;

  localparam logic [PC_W-1:0] RESET_PC_W = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] LAST_PC    = PC_W'(IMEM_DEPTH - 1);
  localparam logic [PC_W-1:0] PC_ONE     = PC_W'(1);

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [31:0]     instr_q, instr_d;
  logic [PC_W-1:0] pc1_q, pc1_d;
  logic            valid_q, valid_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= RUN;
    else        state_q <= state_d;
  end

  // An out-of-range branch target is detected on the edge after the redirect.
  always_comb begin
    state_d = state_q;
    if (branch_taken)
      state_d = RUN;
    else if (state_q == RUN && !stall && pc_q >= LAST_PC)
      state_d = HALT;
  end

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc1_d   = pc1_q;
    valid_d = valid_q;
    halted  = (state_q == HALT);
    if (branch_taken) begin
      pc_d    = branch_target;
      valid_d = 1'b0;
    end else if (state_q == HALT) begin
      valid_d = 1'b0;
    end else if (!stall) begin
      if (pc_q > LAST_PC) begin
        valid_d = 1'b0;
      end else begin
        instr_d = instr_in;
        pc1_d   = pc_q + PC_ONE;
        valid_d = 1'b1;
        if (pc_q != LAST_PC) pc_d = pc_q + PC_ONE;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC_W;
      instr_q <= '0;
      pc1_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc1_q   <= pc1_d;
      valid_q <= valid_d;
    end
  end

  assign pc_out        = pc_q;
  assign ifid_instr    = instr_q;
  assign ifid_pc_plus1 = pc1_q;
  assign ifid_valid    = valid_q;

`ifdef FETCH_STATS_EN
  logic        load_en;
  logic [31:0] fetch_cnt_q, bubble_cnt_q;

  // Stalls in RUN freeze IF/ID, so they count neither a fetch nor a bubble.
  assign load_en = branch_taken || (state_q == HALT) || !stall;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else if (load_en) begin
      if (valid_d && fetch_cnt_q != 32'hFFFF_FFFF)
        fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (!valid_d && bubble_cnt_q != 32'hFFFF_FFFF)
        bubble_cnt_q <= bubble_cnt_q + 32'd1;
    end
  end

  assign fetch_count  = fetch_cnt_q;
  assign bubble_count = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed and random checks of fetch_stage against a word-level model
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc_out, instr_in, ifid_instr, ifid_pc_plus1;
  logic        ifid_valid, halted;
`ifdef FETCH_STATS_EN
  logic [31:0] fetch_count, bubble_count;
`endif

  logic [31:0] imem [256];
  int ncmp = 0;
  int nfail = 0;

  int          m_pc;
  logic [31:0] m_instr;
  int          m_pc1;
  bit          m_valid, m_halt;

  always #5 clk = ~clk;

  always_comb instr_in = (pc_out < 32'd256) ? imem[pc_out[7:0]] : 32'h0;

  fetch_stage #(.RESET_PC(0), .IMEM_DEPTH(256), .PC_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .pc_out(pc_out), .instr_in(instr_in),
    .ifid_instr(ifid_instr), .ifid_pc_plus1(ifid_pc_plus1),
    .ifid_valid(ifid_valid), .halted(halted)
`ifdef FETCH_STATS_EN
    , .fetch_count(fetch_count), .bubble_count(bubble_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0; m_instr = '0; m_pc1 = 0; m_valid = 0; m_halt = 0;
  endtask

  // Word-level behaviour of one clock edge.
  task automatic model_step(input bit st, input bit br, input int tgt);
    if (br) begin
      m_pc = tgt; m_valid = 0; m_halt = 0;
    end else if (m_halt) begin
      m_valid = 0;
    end else if (!st) begin
      if (m_pc >= 256) begin
        m_halt = 1; m_valid = 0;
      end else begin
        m_instr = imem[m_pc]; m_pc1 = m_pc + 1; m_valid = 1;
        if (m_pc == 255) m_halt = 1;
        else m_pc = m_pc + 1;
      end
    end
  endtask

  task automatic check_all();
    chk("pc_out", pc_out, m_pc);
    chk("ifid_valid", {31'b0, ifid_valid}, {31'b0, m_valid});
    chk("halted", {31'b0, halted}, {31'b0, m_halt});
    if (m_valid) begin
      chk("ifid_instr", ifid_instr, m_instr);
      chk("ifid_pc_plus1", ifid_pc_plus1, m_pc1);
    end
  endtask

  task automatic cycle(input bit st, input bit br, input int tgt);
    stall = st; branch_taken = br; branch_target = tgt;
    @(posedge clk);
    model_step(st, br, tgt);
    #1;
    check_all();
  endtask

  task automatic run_to(input int target, input int budget);
    int n = 0;
    while (m_pc != target && n < budget) begin
      cycle(0, 0, 0);
      n++;
    end
    chk("run_to", pc_out, target);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = $urandom;
    imem[0]  = 32'h0109_5020;
    imem[1]  = 32'h0109_5022;
    imem[2]  = 32'h2109_0001;
    imem[11] = 32'h1212_0000;
    model_reset();

    #12;
    chk("rst_pc", pc_out, 32'd0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_instr", ifid_instr, 32'd0);
    chk("rst_pc1", ifid_pc_plus1, 32'd0);
    @(negedge clk); rst_n = 1'b1; #1;
    chk("seq_pc0", pc_out, 32'd0);

    cycle(0, 0, 0);
    chk("seq_pc1", pc_out, 32'd1);
    chk("seq_i0", ifid_instr, 32'h0109_5020);
    chk("seq_p0", ifid_pc_plus1, 32'd1);
    cycle(0, 0, 0);
    chk("seq_pc2", pc_out, 32'd2);
    chk("seq_i1", ifid_instr, 32'h0109_5022);
    chk("seq_p1", ifid_pc_plus1, 32'd2);
    cycle(0, 0, 0);
    chk("seq_i2", ifid_instr, 32'h2109_0001);
    chk("seq_p2", ifid_pc_plus1, 32'd3);
    chk("seq_v2", {31'b0, ifid_valid}, 32'd1);

    repeat (2) begin
      cycle(1, 0, 0);
      chk("stall_pc", pc_out, 32'd3);
      chk("stall_i", ifid_instr, 32'h2109_0001);
      chk("stall_p", ifid_pc_plus1, 32'd3);
    end
    cycle(0, 0, 0);
    chk("unstall_pc", pc_out, 32'd4);
    chk("unstall_i", ifid_instr, imem[3]);

    run_to(11, 20);
    cycle(1, 1, 2);
    chk("br_pc", pc_out, 32'd2);
    chk("br_valid", {31'b0, ifid_valid}, 32'd0);
    cycle(0, 0, 0);
    chk("br_i", ifid_instr, 32'h2109_0001);
    chk("br_v", {31'b0, ifid_valid}, 32'd1);

    run_to(255, 400);
    cycle(0, 0, 0);
    chk("end_i", ifid_instr, imem[255]);
    chk("end_p", ifid_pc_plus1, 32'd256);
    chk("end_halt", {31'b0, halted}, 32'd1);
    repeat (4) begin
      cycle(1'($urandom_range(0, 1)), 0, 0);
      chk("halt_pc", pc_out, 32'd255);
      chk("halt_v", {31'b0, ifid_valid}, 32'd0);
    end
    cycle(0, 1, 0);
    chk("unhalt", {31'b0, halted}, 32'd0);
    chk("unhalt_pc", pc_out, 32'd0);

    run_to(7, 20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_pc", pc_out, 32'd0);
    chk("arst_v", {31'b0, ifid_valid}, 32'd0);
    chk("arst_h", {31'b0, halted}, 32'd0);
    model_reset();
    stall = 0; branch_taken = 0;
    @(negedge clk); rst_n = 1'b1; #1;
    check_all();

    repeat (400) begin
      cycle(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 9) == 0),
            int'($urandom_range(0, 259)));
    end

`ifdef FETCH_STATS_EN
    stall = 0; branch_taken = 0;
    @(negedge clk); rst_n = 1'b0; model_reset();
    @(negedge clk); rst_n = 1'b1; #1;
    repeat (10) cycle(0, 0, 0);
    repeat (3) cycle(1, 0, 0);
    cycle(0, 1, 5);
    chk("fetch_count", fetch_count, 32'd10);
    chk("bubble_count", bubble_count, 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end
endmodule
